// File: rtl/t08_lcd_bus_ctrl.sv
// t08_lcd_bus_ctrl: 8080-style parallel display bus engine fed by a small entry FIFO.
// Entries are {rd, dcx, data}; the engine walks SETUP -> strobe-low -> strobe-high per entry
// and chains straight into the next SETUP when more work is queued, keeping CSX low.
module t08_lcd_bus_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WR_LOW  = 1,
   parameter int unsigned WR_HIGH = 1,
   parameter int unsigned RD_LOW  = 2,
   parameter int unsigned RD_HIGH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_rd,
   input  logic             in_dcx,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic [WIDTH-1:0] bus_out,
   input  logic [WIDTH-1:0] bus_in,
   output logic             bus_oeb,
   output logic             spi_csx,
   output logic             spi_dcx,
   output logic             spi_wrx,
   output logic             spi_rdx
);

   localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(DEPTH + 1);
   localparam int unsigned MaxWr = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
   localparam int unsigned MaxRd = (RD_LOW > RD_HIGH) ? RD_LOW : RD_HIGH;
   localparam int unsigned MaxPh = (MaxWr > MaxRd) ? MaxWr : MaxRd;
   localparam int unsigned PhW   = (MaxPh > 1) ? $clog2(MaxPh) : 1;
   localparam int unsigned EntW  = WIDTH + 2;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StWrLo,
      StWrHi,
      StRdLo,
      StRdHi
   } state_e;

   // FIFO
   logic [EntW-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [EntW-1:0]  head;
   logic             head_rd;
   logic             head_dcx;
   logic [WIDTH-1:0] head_data;

   // FSM and phase counter
   state_e           state_q;
   state_e           state_d;
   logic [PhW-1:0]   ph_q;
   logic [PhW-1:0]   ph_d;
   logic             ph_last;
   logic             rd_q;
   logic             next_rd;
   logic             more;

   // Pin registers
   logic             csx_q;
   logic             wrx_q;
   logic             rdx_q;
   logic             dcx_q;
   logic             oeb_q;
   logic             oeb_d;
   logic [WIDTH-1:0] bus_out_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;

   assign full      = (count_q == CntW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   // in_ready already folds in full, so a push while full is dropped even if a pop coincides
   assign push      = in_valid && !full;

   assign head      = mem_q[rd_ptr_q];
   assign head_rd   = head[EntW-1];
   assign head_dcx  = head[EntW-2];
   assign head_data = head[WIDTH-1:0];

   assign ph_last   = (ph_q == '0);
   assign more      = en && !empty;

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_rd, in_dcx, in_data};
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Next-state, pop decision and phase counter reload/decrement
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (more) begin
               pop     = 1'b1;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (rd_q) begin
               state_d = StRdLo;
               ph_d    = PhW'(RD_LOW - 1);
            end else begin
               state_d = StWrLo;
               ph_d    = PhW'(WR_LOW - 1);
            end
         end
         StWrLo: begin
            if (ph_last) begin
               state_d = StWrHi;
               ph_d    = PhW'(WR_HIGH - 1);
            end else begin
               ph_d = ph_q - 1'b1;
            end
         end
         StRdLo: begin
            if (ph_last) begin
               state_d = StRdHi;
               ph_d    = PhW'(RD_HIGH - 1);
            end else begin
               ph_d = ph_q - 1'b1;
            end
         end
         StWrHi, StRdHi: begin
            if (ph_last) begin
               if (more) begin
                  pop     = 1'b1;
                  state_d = StSetup;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               ph_d = ph_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus drive enable for the upcoming state: driven only for a write from SETUP through WR_HI
   always_comb begin
      oeb_d   = 1'b1;
      next_rd = pop ? head_rd : rd_q;
      unique case (state_d)
         StSetup:        oeb_d = next_rd;
         StWrLo, StWrHi: oeb_d = 1'b0;
         default:        oeb_d = 1'b1;
      endcase
   end

   // State register, phase counter and latched entry kind
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ph_q    <= '0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         if (pop) begin
            rd_q <= head_rd;
         end
      end
   end

   // Pin flops decoded from the next state so each pin changes together with the state
   always_ff @(posedge clk) begin
      if (rst) begin
         csx_q      <= 1'b1;
         wrx_q      <= 1'b1;
         rdx_q      <= 1'b1;
         dcx_q      <= 1'b0;
         oeb_q      <= 1'b1;
         bus_out_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         csx_q      <= (state_d == StIdle);
         wrx_q      <= (state_d != StWrLo);
         rdx_q      <= (state_d != StRdLo);
         oeb_q      <= oeb_d;
         rd_valid_q <= 1'b0;
         if (pop) begin
            dcx_q <= head_dcx;
            // Reads leave the last written value on the (undriven) bus register
            if (!head_rd) begin
               bus_out_q <= head_data;
            end
         end
         if (state_q == StRdLo && ph_last) begin
            rd_data_q  <= bus_in;
            rd_valid_q <= 1'b1;
         end
      end
   end

   assign spi_csx  = csx_q;
   assign spi_wrx  = wrx_q;
   assign spi_rdx  = rdx_q;
   assign spi_dcx  = dcx_q;
   assign bus_oeb  = oeb_q;
   assign bus_out  = bus_out_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_t08_lcd_bus_ctrl.sv
// tb_t08_lcd_bus_ctrl: self-checking bench with a display-side bus model and a scoreboard queue.
module tb_t08_lcd_bus_ctrl;

   localparam int unsigned W = 16;
   localparam int unsigned D = 4;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         en       = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_rd    = 1'b0;
   logic         in_dcx   = 1'b0;
   logic [W-1:0] in_data  = '0;
   logic [W-1:0] bus_in   = '0;
   logic         in_ready;
   logic         rd_valid;
   logic         busy;
   logic         bus_oeb;
   logic         spi_csx;
   logic         spi_dcx;
   logic         spi_wrx;
   logic         spi_rdx;
   logic [W-1:0] rd_data;
   logic [W-1:0] bus_out;

   typedef struct packed {
      logic         rd;
      logic         dcx;
      logic [W-1:0] val;
   } sb_t;

   typedef struct {
      logic         rd;
      logic         dcx;
      logic [W-1:0] data;
      logic [W-1:0] exp;
   } vec_t;

   sb_t          exp_q[$];
   vec_t         vecs[10];
   int           n_checks   = 0;
   int           n_pass     = 0;
   int           n_wr_seen  = 0;
   int           n_rd_seen  = 0;
   logic         pend_v     = 1'b0;
   logic [W-1:0] pend_val   = '0;
   logic         prev_wrx   = 1'b1;
   logic         prev_rdx   = 1'b1;

   always #5 clk = ~clk;

   t08_lcd_bus_ctrl #(
      .WIDTH   (W),
      .DEPTH   (D),
      .WR_LOW  (1),
      .WR_HIGH (1),
      .RD_LOW  (2),
      .RD_HIGH (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_rd    (in_rd),
      .in_dcx   (in_dcx),
      .in_data  (in_data),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .busy     (busy),
      .bus_out  (bus_out),
      .bus_in   (bus_in),
      .bus_oeb  (bus_oeb),
      .spi_csx  (spi_csx),
      .spi_dcx  (spi_dcx),
      .spi_wrx  (spi_wrx),
      .spi_rdx  (spi_rdx)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one entry, waiting (bounded) for space; the expectation is queued as it is accepted
   task automatic push(input logic rd, input logic dcx, input logic [W-1:0] data,
                       input logic [W-1:0] val);
      int  t;
      sb_t e;
      t        = 0;
      in_valid = 1'b1;
      in_rd    = rd;
      in_dcx   = dcx;
      in_data  = data;
      while (in_ready !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      chk("push_accept_in_time", in_ready, 1);
      if (in_ready === 1'b1) begin
         e.rd  = rd;
         e.dcx = dcx;
         e.val = val;
         exp_q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0 || pend_v) && t < 300) begin
         tick();
         t++;
      end
      chk({name, "_busy"}, busy, 0);
      chk({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   // Display-side model: checks every strobe against the scoreboard and answers reads
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         prev_wrx = 1'b1;
         prev_rdx = 1'b1;
         pend_v   = 1'b0;
      end else begin
         if (spi_wrx === 1'b0 && prev_wrx === 1'b1) begin
            n_wr_seen++;
            chk("wr_expected_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_kind", e.rd, 0);
               chk("wr_dcx", spi_dcx, e.dcx);
               chk("wr_data", bus_out, e.val);
               chk("wr_oeb", bus_oeb, 0);
               chk("wr_csx", spi_csx, 0);
            end
         end
         if (spi_rdx === 1'b0 && prev_rdx === 1'b1) begin
            n_rd_seen++;
            chk("rd_expected_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rd_kind", e.rd, 1);
               chk("rd_dcx", spi_dcx, e.dcx);
               chk("rd_oeb", bus_oeb, 1);
               chk("rd_csx", spi_csx, 0);
               bus_in   = e.val;
               pend_v   = 1'b1;
               pend_val = e.val;
            end
         end
         if (spi_rdx === 1'b1 && prev_rdx === 1'b0) begin
            bus_in = 16'h5A5A;
         end
         if (rd_valid === 1'b1) begin
            chk("rd_valid_expected", pend_v, 1);
            chk("rd_valid_first_rd_hi", {prev_rdx, spi_rdx}, 2'b01);
            chk("rd_data", rd_data, pend_val);
            pend_v = 1'b0;
         end
         prev_wrx = spi_wrx;
         prev_rdx = spi_rdx;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          act;
      int          cs_low;
      int          wr_low;
      int          rd_low;
      int          oeb_low;
      int          rv_cnt;
      int          falls;
      int          last;
      int          cs_gap;
      int          t;
      int          wr0;
      int          rd0;
      int          nwr;
      int          nrd;
      logic        pw;
      logic [W-1:0] cap;
      sb_t         e;

      vecs[0] = '{1'b0, 1'b0, 16'h0101, 16'h0101};
      vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 16'hA001};
      vecs[2] = '{1'b0, 1'b1, 16'h0202, 16'h0202};
      vecs[3] = '{1'b0, 1'b1, 16'h0303, 16'h0303};
      vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'hA002};
      vecs[5] = '{1'b0, 1'b0, 16'h0404, 16'h0404};
      vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'hA003};
      vecs[7] = '{1'b0, 1'b1, 16'h0505, 16'h0505};
      vecs[8] = '{1'b1, 1'b1, 16'hFFFF, 16'hA004};
      vecs[9] = '{1'b0, 1'b0, 16'h0606, 16'h0606};

      // Reset, then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_csx", spi_csx, 1);
      chk("rst_wrx", spi_wrx, 1);
      chk("rst_rdx", spi_rdx, 1);
      chk("rst_dcx", spi_dcx, 0);
      chk("rst_bus_out", bus_out, 0);
      chk("rst_oeb", bus_oeb, 1);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      act = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (spi_csx !== 1'b1 || spi_wrx !== 1'b1 || spi_rdx !== 1'b1 || rd_valid !== 1'b0 ||
             busy !== 1'b0) act++;
      end
      chk("idle_no_activity", act, 0);

      // Single command write
      tick();
      en = 1'b1;
      push(1'b0, 1'b0, 16'h002A, 16'h002A);
      cs_low = 0;
      wr_low = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (spi_csx === 1'b0) cs_low++;
         if (spi_wrx === 1'b0) wr_low++;
      end
      chk("single_csx_low_cycles", cs_low, 3);
      chk("single_wrx_low_cycles", wr_low, 1);
      chk("single_csx_back_high", spi_csx, 1);
      chk("single_busy_clear", busy, 0);
      tick();
      wait_idle("single");

      // Burst into a held-off engine; fifth push must be dropped
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_rd    = 1'b0;
         in_dcx   = 1'b1;
         in_data  = W'(i + 1);
         chk($sformatf("burst_in_ready_%0d", i), in_ready, (i < 4));
         if (i < 4) begin
            e.rd  = 1'b0;
            e.dcx = 1'b1;
            e.val = W'(i + 1);
            exp_q.push_back(e);
         end
         tick();
      end
      in_valid = 1'b0;
      chk("burst_full_ready_low", in_ready, 0);
      chk("burst_busy_while_held", busy, 1);
      en     = 1'b1;
      falls  = 0;
      last   = 0;
      cs_gap = 0;
      pw     = spi_wrx;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (falls >= 1 && falls <= 3 && spi_csx !== 1'b0) cs_gap++;
         if (spi_wrx === 1'b0 && pw === 1'b1) begin
            if (falls > 0) chk($sformatf("burst_period_%0d", falls), i - last, 3);
            falls++;
            last = i;
         end
         pw = spi_wrx;
      end
      chk("burst_wrx_pulses", falls, 4);
      chk("burst_csx_held_low", cs_gap, 0);
      tick();
      wait_idle("burst");

      // Single read with dcx=1
      push(1'b1, 1'b1, 16'h0000, 16'hBEEF);
      rd_low  = 0;
      oeb_low = 0;
      rv_cnt  = 0;
      cap     = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (spi_rdx === 1'b0) rd_low++;
         if (bus_oeb !== 1'b1) oeb_low++;
         if (rd_valid === 1'b1) begin
            rv_cnt++;
            cap = rd_data;
         end
      end
      chk("read_rdx_low_cycles", rd_low, 2);
      chk("read_oeb_never_low", oeb_low, 0);
      chk("read_valid_pulses", rv_cnt, 1);
      chk("read_data_beef", cap, 16'hBEEF);
      tick();
      wait_idle("read");

      // Mixed traffic across pointer wrap
      wr0 = n_wr_seen;
      rd0 = n_rd_seen;
      nwr = 0;
      nrd = 0;
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].rd) nrd++;
         else nwr++;
         push(vecs[i].rd, vecs[i].dcx, vecs[i].data, vecs[i].exp);
      end
      wait_idle("wrap");
      chk("wrap_write_count", n_wr_seen - wr0, nwr);
      chk("wrap_read_count", n_rd_seen - rd0, nrd);

      // Reset while a write strobe is low with two entries still queued
      en = 1'b0;
      push(1'b0, 1'b1, 16'h0011, 16'h0011);
      push(1'b0, 1'b1, 16'h0022, 16'h0022);
      push(1'b0, 1'b1, 16'h0033, 16'h0033);
      en = 1'b1;
      t  = 0;
      while (spi_wrx !== 1'b0 && t < 20) begin
         tick();
         t++;
      end
      chk("mid_reached_wr_lo", spi_wrx, 0);
      rst = 1'b1;
      tick();
      chk("mid_rst_wrx", spi_wrx, 1);
      chk("mid_rst_csx", spi_csx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_rd_valid", rd_valid, 0);
      rst = 1'b0;
      exp_q.delete();
      act = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (spi_csx !== 1'b1 || spi_wrx !== 1'b1 || spi_rdx !== 1'b1 || rd_valid !== 1'b0 ||
             busy !== 1'b0) act++;
      end
      chk("mid_rst_no_further_activity", act, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
